sharpen_window_ctrl: RTL and testbench
======================================

# sharpen_window_ctrl

Sequencer for the 800x600 sharpening pipeline. It walks every interior pixel in raster order. For each one it issues the nine 3x3-neighbourhood reads to the single-port synchronous image memory, collects the returned pixels, and presents them with the centre-pixel output address to the update stage register through a valid/ready handshake. It sits between the image memory and the update stage, and owns all address generation and frame start/done signalling.

## Interface
Parameters:
- IMG_W, 800, image width in pixels
- IMG_H, 600, image height in pixels
- AW, 19, address width (must satisfy IMG_W*IMG_H <= 2^AW)
- DW, 8, pixel width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse when the last window is accepted
- mem_addr  out  AW  read address to image memory
- mem_re  out  1  read enable
- mem_rdata  in  DW  read data, valid the cycle after mem_re
- win_valid  out  1  window and address are valid
- win_ready  in  1  update stage accepts the window
- win_oa  out  AW  output (centre) address = r*IMG_W + c
- win_v  out  9*DW  window pixels; v0 in [DW-1:0] ... v8 in [9*DW-1:8*DW]

## Operation
- Window order:
  - v0..v2 = row r-1, cols c-1..c+1
  - v3..v5 = row r, cols c-1..c+1
  - v6..v8 = row r+1, cols c-1..c+1
- Centre range: r in 1..IMG_H-2, c in 1..IMG_W-2. That is 798x598 = 477204 windows per frame. Border pixels are not generated.
- Address arithmetic:
  - base = (r-1)*IMG_W + (c-1), kept as a running row-base register plus a column counter (no multiplier).
  - Read k uses base + (k/3)*IMG_W + (k%3).
  - win_oa = base + IMG_W + 1.
  - All arithmetic is unsigned AW-bit; no overflow is possible within range.
- States:
  - IDLE: outputs quiescent. start=1 sets r=1, c=1, goes to FETCH.
  - FETCH: 9 cycles, k=0..8. mem_re=1, mem_addr = address k. The data from read k-1 is captured into v[k-1] for k>=1. After k=8, goes to CAP.
  - CAP: 1 cycle. mem_re=0, mem_rdata captured into v8. Goes to PRESENT.
  - PRESENT: win_valid=1; win_v and win_oa stable.
    - If win_ready=1, the window is accepted that cycle.
    - If this was the last window (r=IMG_H-2, c=IMG_W-2), go to DONE.
    - Otherwise advance: c+1. If c was IMG_W-2, wrap to c=1, r+1, row base += IMG_W. Then go to FETCH.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. win_ready is ignored outside PRESENT.

## Timing
- Reset values: state IDLE; busy, done, mem_re, win_valid = 0; mem_addr, win_oa, win_v = 0; r and c = 0.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight read data is discarded and there is no done pulse.
- Latency per window is 11 cycles minimum: 9 FETCH + 1 CAP + 1 PRESENT with win_ready high.
- start accepted at edge t gives the first mem_re=1 in cycle t+1. The first win_valid is in cycle t+11.
- Backpressure: while win_valid=1 and win_ready=0, every output holds and no reads are issued.
- mem_addr holds its last value when mem_re=0.
- win_ready high before win_valid has no effect.
- The handshake completes on the edge where win_valid and win_ready are both 1.
- The update stage captures on the falling clock edge. win_v and win_oa therefore change only on rising edges and stay stable for the whole PRESENT cycle.

## Test plan
- Reset: hold reset 3 cycles mid-FETCH of window 5 -> all outputs 0, state IDLE, no done pulse. A subsequent start restarts at r=1, c=1.
- First window: start with win_ready=1 and memory data = addr[7:0] -> mem_addr sequence 0,1,2,800,801,802,1600,1601,1602. win_oa=801. win_v bytes = 00,01,02,20,21,22,40,41,42 (hex).
- Row wrap: the window after the one at (r=1, c=798) -> first read address 800, win_oa=1601.
- Backpressure: hold win_ready=0 for 7 cycles in PRESENT -> win_valid, win_oa and win_v stable, mem_re=0. Acceptance happens on the first ready cycle and the next FETCH starts immediately.
- Full frame with win_ready=1 -> 477204 accepted windows; last win_oa = 479198; done pulses once the cycle after the last acceptance; busy then falls.
- start pulsed while busy -> ignored: window count and sequence unchanged from the previous test.

Source files
------------

// File: rtl/sharpen_window_ctrl_if.sv
// Bus bundle for the sharpening window sequencer.
// Carries the frame control (start/busy/done), the image-memory read port
// (mem_addr/mem_re/mem_rdata) and the window handshake toward the update
// stage (win_valid/win_ready/win_oa/win_v).
// master: the sequencer side; slave: the memory / update-stage / host side.
interface sharpen_window_ctrl_if #(
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 8
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic [AW-1:0]     mem_addr;
    logic              mem_re;
    logic [DW-1:0]     mem_rdata;
    logic              win_valid;
    logic              win_ready;
    logic [AW-1:0]     win_oa;
    logic [9*DW-1:0]   win_v;

    modport master (
        input  start,
        output busy,
        output done,
        output mem_addr,
        output mem_re,
        input  mem_rdata,
        output win_valid,
        input  win_ready,
        output win_oa,
        output win_v
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  mem_addr,
        input  mem_re,
        output mem_rdata,
        input  win_valid,
        output win_ready,
        input  win_oa,
        input  win_v
    );
endinterface

// File: rtl/sharpen_window_ctrl.sv
// Raster-order 3x3 window sequencer for the sharpening pipeline.
// For each interior pixel it issues nine reads to a single-port synchronous
// memory, assembles the neighbourhood and offers it with the centre address
// on a valid/ready handshake.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - sharpen_window_ctrl_if.master (start/busy/done, memory read
//           port, window handshake); all outputs are registered.
module sharpen_window_ctrl #(
    parameter int unsigned IMG_W = 800,
    parameter int unsigned IMG_H = 600,
    parameter int unsigned AW    = 19,
    parameter int unsigned DW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sharpen_window_ctrl_if.master bus
);

    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] LAST_R   = AW'(IMG_H - 2);
    localparam logic [AW-1:0] LAST_C   = AW'(IMG_W - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAP,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic [3:0]      k, k_d;
    logic [AW-1:0]   r, r_d, c, c_d, row_base, row_base_d;
    logic [AW-1:0]   mem_addr_d, win_oa_d;
    logic            mem_re_d, win_valid_d, busy_d, done_d;
    logic [9*DW-1:0] win_v_d;

    // Next-state and next-output logic; every register gets its next value here.
    always_comb begin
        state_d     = state;
        k_d         = k;
        r_d         = r;
        c_d         = c;
        row_base_d  = row_base;
        mem_addr_d  = bus.mem_addr;
        mem_re_d    = 1'b0;
        win_valid_d = 1'b0;
        win_oa_d    = bus.win_oa;
        win_v_d     = bus.win_v;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    r_d        = AW'(1);
                    c_d        = AW'(1);
                    row_base_d = '0;
                    k_d        = '0;
                    mem_re_d   = 1'b1;
                    mem_addr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // Data for read k-1 arrives while read k is being issued.
                for (int i = 0; i < 8; i++) begin
                    if (k == 4'(i + 1)) win_v_d[i*DW +: DW] = bus.mem_rdata;
                end
                if (k == 4'd8) begin
                    state_d = S_CAP;
                end else begin
                    k_d      = k + 4'd1;
                    mem_re_d = 1'b1;
                    // Step to the next neighbourhood row after columns 2 and 5.
                    if (k == 4'd2 || k == 4'd5) mem_addr_d = bus.mem_addr + ROW_STEP - AW'(2);
                    else                        mem_addr_d = bus.mem_addr + AW'(1);
                end
            end
            S_CAP: begin
                win_v_d[8*DW +: DW] = bus.mem_rdata;
                win_valid_d         = 1'b1;
                win_oa_d            = row_base + ROW_STEP + c;
                state_d             = S_PRESENT;
            end
            S_PRESENT: begin
                win_valid_d = ~bus.win_ready;
                if (bus.win_ready) begin
                    if (r == LAST_R && c == LAST_C) begin
                        state_d = S_DONE;
                    end else begin
                        if (c == LAST_C) begin
                            c_d        = AW'(1);
                            r_d        = r + AW'(1);
                            row_base_d = row_base + ROW_STEP;
                            mem_addr_d = row_base + ROW_STEP;
                        end else begin
                            c_d        = c + AW'(1);
                            mem_addr_d = row_base + c;
                        end
                        k_d      = '0;
                        mem_re_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            k             <= '0;
            r             <= '0;
            c             <= '0;
            row_base      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_re    <= 1'b0;
            bus.win_valid <= 1'b0;
            bus.win_oa    <= '0;
            bus.win_v     <= '0;
        end else begin
            state         <= state_d;
            k             <= k_d;
            r             <= r_d;
            c             <= c_d;
            row_base      <= row_base_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_re    <= mem_re_d;
            bus.win_valid <= win_valid_d;
            bus.win_oa    <= win_oa_d;
            bus.win_v     <= win_v_d;
        end
    end

endmodule

// File: tb/tb_sharpen_window_ctrl.sv
// Self-checking bench for sharpen_window_ctrl on a reduced 16x6 image so a
// whole frame fits in a short run. A synchronous memory model returns a
// seeded hash of the address; the expected window for each accepted index n
// is computed directly from its (r, c) position in raster order.
module tb_sharpen_window_ctrl;

    localparam int unsigned IMG_W = 16;
    localparam int unsigned IMG_H = 6;
    localparam int unsigned AW    = 19;
    localparam int unsigned DW    = 8;
    localparam int unsigned N_WIN = (IMG_W - 2) * (IMG_H - 2);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sharpen_window_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sharpen_window_ctrl #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [7:0]  seed        = 8'h00;
    int unsigned n_acc;
    logic [AW-1:0] addr_q[$];

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'h25;
        return t ^ seed;
    endfunction

    // Synchronous read memory; junk is returned when no read was issued.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mdata(bus.mem_addr);
        else            bus.mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},      128'(bus.busy),      128'(0));
        chk({tag, "_done"},      128'(bus.done),      128'(0));
        chk({tag, "_mem_re"},    128'(bus.mem_re),    128'(0));
        chk({tag, "_win_valid"}, 128'(bus.win_valid), 128'(0));
        chk({tag, "_mem_addr"},  128'(bus.mem_addr),  128'(0));
        chk({tag, "_win_oa"},    128'(bus.win_oa),    128'(0));
        chk({tag, "_win_v"},     128'(bus.win_v),     128'(0));
    endtask

    // Compare the presented window against window index n of the frame.
    task automatic check_window(input int unsigned n);
        int unsigned r    = 1 + n / (IMG_W - 2);
        int unsigned c    = 1 + n % (IMG_W - 2);
        int unsigned base = (r - 1) * IMG_W + (c - 1);
        logic [9*DW-1:0] ev;
        for (int k = 0; k < 9; k++)
            ev[k*DW +: DW] = mdata(AW'(base + (k / 3) * IMG_W + k % 3));
        chk("win_oa", 128'(bus.win_oa), 128'(r * IMG_W + c));
        chk("win_v",  128'(bus.win_v),  128'(ev));
        chk("read_count", 128'(addr_q.size()), 128'(9));
        for (int k = 0; k < 9; k++)
            if (k < addr_q.size())
                chk("read_addr", 128'(addr_q[k]), 128'(base + (k / 3) * IMG_W + k % 3));
        if (n == IMG_W - 2 && addr_q.size() > 0) begin
            chk("row_wrap_addr0", 128'(addr_q[0]), 128'(IMG_W));
            chk("row_wrap_oa", 128'(bus.win_oa), 128'(2 * IMG_W + 1));
        end
        if (n == N_WIN - 1)
            chk("last_oa", 128'(bus.win_oa), 128'((IMG_H - 2) * IMG_W + IMG_W - 2));
    endtask

    // Runs one frame from IDLE. rnd: random ready with a forced 7-cycle stall;
    // abort5: pull reset during the FETCH of the fifth window.
    task automatic run_frame(input bit rnd, input bit abort5);
        int unsigned cyc = 0, stall = 0, budget = N_WIN * 40 + 50;
        bit first_valid = 1'b0, pend_stall = 1'b0, pend_done = 1'b0;
        bit pend_fetch = 1'b0, finished = 1'b0;
        logic rdy;
        n_acc = 0;
        addr_q.delete();
        seed = 8'($urandom);
        chk("idle_busy", 128'(bus.busy), 128'(0));
        bus.start     = 1'b1;
        bus.win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!finished) begin
            if (bus.mem_re) addr_q.push_back(bus.mem_addr);
            if (cyc == 1) begin
                chk("start_busy",   128'(bus.busy),     128'(1));
                chk("start_mem_re", 128'(bus.mem_re),   128'(1));
                chk("start_addr",   128'(bus.mem_addr), 128'(0));
            end
            if (abort5 && n_acc == 4 && addr_q.size() == 4) begin
                reset     = 1'b1;
                bus.start = 1'b0;
                repeat (3) begin
                    @(posedge clk); @(negedge clk);
                    check_quiet("mid_reset");
                end
                reset = 1'b0;
                @(posedge clk); @(negedge clk);
                check_quiet("post_reset");
                return;
            end
            if (pend_stall) begin
                chk("stall_valid",  128'(bus.win_valid), 128'(1));
                chk("stall_mem_re", 128'(bus.mem_re),    128'(0));
            end
            if (pend_fetch) chk("fetch_after_accept", 128'(bus.mem_re), 128'(1));
            chk("done", 128'(bus.done), 128'(pend_done));
            if (pend_done) begin
                chk("busy_in_done", 128'(bus.busy), 128'(1));
                finished = 1'b1;
            end
            if (bus.win_valid && !first_valid) begin
                first_valid = 1'b1;
                chk("first_valid_latency", 128'(cyc), 128'(11));
            end

            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd && bus.win_valid && n_acc == 2 && stall < 7) begin
                rdy = 1'b0;
                stall++;
            end
            bus.start = bus.busy && ($urandom_range(0, 7) == 0);

            pend_stall = 1'b0;
            pend_done  = 1'b0;
            pend_fetch = 1'b0;
            if (bus.win_valid) begin
                check_window(n_acc);
                if (rdy) begin
                    n_acc++;
                    addr_q.delete();
                    pend_done  = (n_acc == N_WIN);
                    pend_fetch = !pend_done;
                end else begin
                    pend_stall = 1'b1;
                end
            end
            bus.win_ready = rdy;
            if (finished) begin
                bus.start     = 1'b0;
                bus.win_ready = 1'b0;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                chk("frame_timeout", 128'(n_acc), 128'(N_WIN));
                finished = 1'b1;
            end
        end
        chk("end_busy",  128'(bus.busy),      128'(0));
        chk("end_done",  128'(bus.done),      128'(0));
        chk("end_valid", 128'(bus.win_valid), 128'(0));
        chk("win_count", 128'(n_acc),         128'(N_WIN));
        if (rnd) chk("stall_cycles", 128'(stall), 128'(7));
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.win_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check_quiet("idle");

        run_frame(1'b1, 1'b1);
        run_frame(1'b1, 1'b0);
        run_frame(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
